// File: rtl/bingo_task_fetcher_pkg.sv
// Shared types and helpers for the Bingo task fetcher: FSM state encoding,
// descriptor type and the descriptor address offset computation.
package bingo_task_fetcher_pkg;

  localparam int unsigned DescWidth = 64;
  localparam int unsigned DescBytes = 8;
  localparam int unsigned FifoDepth = 4;
  localparam int unsigned AddrWidth = 48;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_e;

  typedef logic [DescWidth-1:0] task_desc_t;

  // Byte offset of descriptor number 'index' in a list with the given stride.
  // Returned wide; the caller truncates to its address width so the
  // resulting address wraps silently.
  function automatic logic [63:0] desc_offset(input logic [31:0] index,
                                              input int unsigned stride);
    return 64'(index) * 64'(stride);
  endfunction

endpackage

// File: rtl/fifo_v3.sv
// Small synchronous FIFO in the style of common_cells fifo_v3.
// usage_o carries the full fill level (0..DEPTH). A push into a full FIFO is
// accepted when a pop happens in the same cycle. DEPTH must be a power of two.
module fifo_v3 #(
  parameter bit          FALL_THROUGH = 1'b0,
  parameter int unsigned DATA_WIDTH   = 32,
  parameter int unsigned DEPTH        = 8,
  parameter int unsigned ADDR_DEPTH   = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  flush_i,
  input  logic                  testmode_i,
  output logic                  full_o,
  output logic                  empty_o,
  output logic [ADDR_DEPTH:0]   usage_o,
  input  logic [DATA_WIDTH-1:0] data_i,
  input  logic                  push_i,
  output logic [DATA_WIDTH-1:0] data_o,
  input  logic                  pop_i
);

  logic [ADDR_DEPTH-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_DEPTH-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_DEPTH:0]   count_q, count_d;
  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [DATA_WIDTH-1:0] mem_d [DEPTH];
  logic                  push_en;
  logic                  pop_en;
  logic                  unused_testmode;

  assign unused_testmode = testmode_i;
  assign full_o  = (count_q == (ADDR_DEPTH+1)'(DEPTH));
  assign empty_o = (count_q == '0);
  assign usage_o = count_q;

  // Pointer, fill level and storage update for push/pop/flush.
  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    mem_d    = mem_q;
    push_en  = push_i & (~full_o | pop_i);
    pop_en   = pop_i & ~empty_o;
    data_o   = mem_q[rd_ptr_q];

    if (FALL_THROUGH && empty_o && push_i) begin
      data_o = data_i;
      if (pop_i) begin
        push_en = 1'b0;
      end
    end

    if (push_en) begin
      mem_d[wr_ptr_q] = data_i;
      wr_ptr_d        = wr_ptr_q + ADDR_DEPTH'(1);
    end
    if (pop_en) begin
      rd_ptr_d = rd_ptr_q + ADDR_DEPTH'(1);
    end

    case ({push_en, pop_en})
      2'b10:   count_d = count_q + (ADDR_DEPTH+1)'(1);
      2'b01:   count_d = count_q - (ADDR_DEPTH+1)'(1);
      default: count_d = count_q;
    endcase

    if (flush_i) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
      mem_d    = mem_q;
    end
  end

  // FIFO state registers; storage is cleared so the head reads 0 after reset.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      mem_q    <= mem_d;
    end
  end

endmodule

// File: rtl/bingo_task_fetcher.sv
// Bingo task fetcher: streams a task-descriptor list from memory into a small
// FIFO and presents it on a valid/ready task stream, then clears the start
// register. Optional performance counters are enabled with the macro
// BINGO_TASK_FETCHER_PERF_EN.
module bingo_task_fetcher #(
  parameter int unsigned DescWidth = 64,
  parameter int unsigned DescBytes = 8,
  parameter int unsigned FifoDepth = 4,
  parameter int unsigned AddrWidth = 48
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic [AddrWidth-1:0] base_addr_i,
  input  logic [31:0]          num_task_i,
  input  logic [31:0]          start_i,
  output logic [31:0]          reset_start_o,
  output logic                 reset_start_en_o,
`ifdef BINGO_TASK_FETCHER_PERF_EN
  output logic [31:0]          perf_cycles_o,
  output logic [31:0]          perf_stall_o,
`endif
  output logic                 mem_req_valid_o,
  input  logic                 mem_req_ready_i,
  output logic [AddrWidth-1:0] mem_req_addr_o,
  input  logic                 mem_rsp_valid_i,
  input  logic [DescWidth-1:0] mem_rsp_data_i,
  output logic                 task_valid_o,
  input  logic                 task_ready_i,
  output logic [DescWidth-1:0] task_desc_o,
  output logic                 busy_o
);

  import bingo_task_fetcher_pkg::*;

  localparam int unsigned OutWidth = $clog2(FifoDepth) + 1;

  state_e               state_q, state_d;
  logic [AddrWidth-1:0] base_q, base_d;
  logic [31:0]          num_q, num_d;
  logic [31:0]          issued_q, issued_d;
  logic [OutWidth-1:0]  outstanding_q, outstanding_d;

  logic [OutWidth-1:0]  fifo_count;
  logic                 fifo_full;
  logic                 fifo_empty;
  logic [OutWidth:0]    in_flight;
  logic                 credit_avail;
  logic                 more_to_issue;
  logic                 req_hs;
  logic                 rsp_accept;
  logic                 fifo_pop;
  logic                 unused_bits;

  assign unused_bits = ^{start_i[31:1], fifo_full};

  // Credit is what is left of the FIFO after buffered and in-flight beats.
  assign in_flight     = {1'b0, fifo_count} + {1'b0, outstanding_q};
  assign credit_avail  = (in_flight < (OutWidth+1)'(FifoDepth));
  assign more_to_issue = (issued_q < num_q);

  assign mem_req_valid_o = (state_q == FETCH) && more_to_issue && credit_avail;
  assign mem_req_addr_o  = base_q + AddrWidth'(desc_offset(issued_q, DescBytes));
  assign req_hs          = mem_req_valid_o & mem_req_ready_i;

  // Responses without a matching request are dropped rather than buffered.
  assign rsp_accept    = mem_rsp_valid_i && (outstanding_q != '0);
  assign task_valid_o  = ~fifo_empty;
  assign fifo_pop      = task_valid_o & task_ready_i;
  assign reset_start_o = '0;

  fifo_v3 #(
    .FALL_THROUGH (1'b0),
    .DATA_WIDTH   (DescWidth),
    .DEPTH        (FifoDepth)
  ) i_desc_fifo (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .flush_i    (1'b0),
    .testmode_i (1'b0),
    .full_o     (fifo_full),
    .empty_o    (fifo_empty),
    .usage_o    (fifo_count),
    .data_i     (mem_rsp_data_i),
    .push_i     (rsp_accept),
    .data_o     (task_desc_o),
    .pop_i      (fifo_pop)
  );

  // Outstanding reads: a request and a response in the same cycle cancel out.
  always_comb begin
    outstanding_d = outstanding_q;
    if (req_hs && !rsp_accept) begin
      outstanding_d = outstanding_q + OutWidth'(1);
    end else if (!req_hs && rsp_accept) begin
      outstanding_d = outstanding_q - OutWidth'(1);
    end
  end

  // Run control: launch, issue requests, wait for drain, pulse the clear.
  always_comb begin
    state_d          = state_q;
    base_d           = base_q;
    num_d            = num_q;
    issued_d         = issued_q;
    reset_start_en_o = 1'b0;
    busy_o           = (state_q != IDLE);

    case (state_q)
      IDLE: begin
        if (start_i[0]) begin
          base_d   = base_addr_i;
          num_d    = num_task_i;
          issued_d = '0;
          state_d  = (num_task_i == '0) ? DONE : FETCH;
        end
      end
      FETCH: begin
        if (req_hs) begin
          issued_d = issued_q + 32'd1;
          if (issued_d == num_q) begin
            state_d = DRAIN;
          end
        end
      end
      DRAIN: begin
        if ((outstanding_q == '0) && fifo_empty) begin
          state_d = DONE;
        end
      end
      DONE: begin
        reset_start_en_o = 1'b1;
        state_d          = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Run state and counter registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q       <= IDLE;
      base_q        <= '0;
      num_q         <= '0;
      issued_q      <= '0;
      outstanding_q <= '0;
    end else begin
      state_q       <= state_d;
      base_q        <= base_d;
      num_q         <= num_d;
      issued_q      <= issued_d;
      outstanding_q <= outstanding_d;
    end
  end

`ifdef BINGO_TASK_FETCHER_PERF_EN
  logic [31:0] perf_cycles_q, perf_cycles_d;
  logic [31:0] perf_stall_q, perf_stall_d;

  // Busy-cycle and credit-stall counters, cleared on launch, saturating.
  always_comb begin
    perf_cycles_d = perf_cycles_q;
    perf_stall_d  = perf_stall_q;
    if (state_q == IDLE) begin
      if (start_i[0]) begin
        perf_cycles_d = '0;
        perf_stall_d  = '0;
      end
    end else begin
      if (perf_cycles_q != '1) begin
        perf_cycles_d = perf_cycles_q + 32'd1;
      end
      if ((state_q == FETCH) && more_to_issue && !credit_avail &&
          (perf_stall_q != '1)) begin
        perf_stall_d = perf_stall_q + 32'd1;
      end
    end
  end

  // Performance counter registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      perf_cycles_q <= '0;
      perf_stall_q  <= '0;
    end else begin
      perf_cycles_q <= perf_cycles_d;
      perf_stall_q  <= perf_stall_d;
    end
  end

  assign perf_cycles_o = perf_cycles_q;
  assign perf_stall_o  = perf_stall_q;
`endif

  rsp_needs_request: assert property (@(posedge clk_i) disable iff (!rst_ni)
    mem_rsp_valid_i |-> (outstanding_q != '0));

endmodule
